// File: rtl/turnstile_lane_arbiter.sv
// Round-robin arbiter sharing one access-code checker and door timer across turnstile lanes.
// Optional pass counter output is enabled by defining TURNSTILE_PASS_COUNT_EN.
module turnstile_lane_arbiter #(
  parameter int NUM_LANES   = 4,
  parameter int CODE_W      = 4,
  parameter int CODE_MIN    = 4,
  parameter int CODE_MAX    = 11,
  parameter int OPEN_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_LANES-1:0]        lane_req,
  input  logic [NUM_LANES*CODE_W-1:0] lane_code,
  output logic [NUM_LANES-1:0]        lane_ack,
  output logic [NUM_LANES-1:0]        lane_open,
  output logic [NUM_LANES-1:0]        lane_deny,
  output logic                        busy,
`ifdef TURNSTILE_PASS_COUNT_EN
  output logic [15:0]                 pass_count,
`endif
  output logic [1:0]                  state_out
);

  // Handshake: a lane holds lane_req until lane_ack pulses; after that it must
  // drop lane_req, otherwise it is arbitrated again as a fresh request.
  localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CW    = PTR_W + 1;
  localparam int TMR_W = $clog2(OPEN_CYCLES + 1);

  localparam logic [CW-1:0]     LANES_X  = CW'(NUM_LANES);
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NUM_LANES - 1);
  localparam logic [CODE_W-1:0] MIN_C    = CODE_W'(CODE_MIN);
  localparam logic [CODE_W-1:0] MAX_C    = CODE_W'(CODE_MAX);
  localparam logic [TMR_W-1:0]  TERM     = TMR_W'(OPEN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    GRANT = 2'b10,
    DENY  = 2'b11
  } state_t;

  state_t              state, state_n;
  logic [PTR_W-1:0]    sel, sel_n;
  logic [PTR_W-1:0]    rr_ptr, rr_ptr_n;
  logic [CODE_W-1:0]   code, code_n;
  logic [TMR_W-1:0]    timer, timer_n;
  logic [NUM_LANES-1:0] ack_n, open_n, deny_n;

  logic [PTR_W-1:0]    pick;
  logic                found;
  logic [CW-1:0]       cand;
  logic                code_ok;

  function automatic logic [NUM_LANES-1:0] lane_bit(input logic [PTR_W-1:0] idx);
    lane_bit      = '0;
    lane_bit[idx] = 1'b1;
  endfunction

  // First requesting lane at or after rr_ptr, wrapping past the last lane.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cand = {1'b0, rr_ptr} + CW'(i);
      if (cand >= LANES_X) cand = cand - LANES_X;
      if (!found && lane_req[cand[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[PTR_W-1:0];
      end
    end
  end

  assign code_ok = (code >= MIN_C) && (code <= MAX_C);

  always_comb begin
    state_n  = state;
    sel_n    = sel;
    rr_ptr_n = rr_ptr;
    code_n   = code;
    timer_n  = '0;
    ack_n    = '0;
    open_n   = '0;
    deny_n   = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n  = CHECK;
          sel_n    = pick;
          code_n   = lane_code[int'(pick)*CODE_W +: CODE_W];
          ack_n    = lane_bit(pick);
          rr_ptr_n = (pick == LAST_IDX) ? '0 : pick + PTR_W'(1);
        end
      end
      CHECK: begin
        if (code_ok) begin
          state_n = GRANT;
          open_n  = lane_bit(sel);
        end else begin
          state_n = DENY;
          deny_n  = lane_bit(sel);
        end
      end
      GRANT: begin
        if (timer == TERM) begin
          state_n = IDLE;
        end else begin
          timer_n = timer + TMR_W'(1);
          open_n  = lane_bit(sel);
        end
      end
      DENY: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Every output is a flop so doors close at once on asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      rr_ptr    <= '0;
      code      <= '0;
      timer     <= '0;
      lane_ack  <= '0;
      lane_open <= '0;
      lane_deny <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      rr_ptr    <= rr_ptr_n;
      code      <= code_n;
      timer     <= timer_n;
      lane_ack  <= ack_n;
      lane_open <= open_n;
      lane_deny <= deny_n;
      busy      <= (state_n != IDLE);
    end
  end

  assign state_out = state;

`ifdef TURNSTILE_PASS_COUNT_EN
  logic [15:0] pass_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= '0;
    end else if (state == CHECK && state_n == GRANT && pass_q != 16'hFFFF) begin
      pass_q <= pass_q + 16'd1;
    end
  end

  assign pass_count = pass_q;
`endif

endmodule

// File: tb/tb_turnstile_lane_arbiter.sv
// Scoreboard bench: a batch-level round-robin model predicts service order and outcome,
// a negedge monitor pops and checks each service against the DUT outputs.
module tb_turnstile_lane_arbiter;

  localparam int N     = 4;
  localparam int CW    = 4;
  localparam int CMIN  = 4;
  localparam int CMAX  = 11;
  localparam int OPENC = 16;

  typedef struct packed {
    logic [7:0]  lane;
    logic        grant;
    logic        first;
    logic        b2b;
    logic [31:0] apply_cyc;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      lane_req;
  logic [N*CW-1:0]   lane_code;
  logic [N-1:0]      lane_ack;
  logic [N-1:0]      lane_open;
  logic [N-1:0]      lane_deny;
  logic              busy;
  logic [1:0]        state_out;
`ifdef TURNSTILE_PASS_COUNT_EN
  logic [15:0]       pass_count;
`endif

  exp_t exp_q[$];
  exp_t cur;
  int   checks_n = 0;
  int   errs_n = 0;
  int   cyc = 0;
  int   model_ptr = 0;
  int   exp_grants = 0;
  int   phase = 0;
  int   open_cnt = 0;
  int   last_end = 0;
  bit   mon_en = 0;

  turnstile_lane_arbiter #(
    .NUM_LANES(N), .CODE_W(CW), .CODE_MIN(CMIN), .CODE_MAX(CMAX), .OPEN_CYCLES(OPENC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .lane_req(lane_req),
    .lane_code(lane_code),
    .lane_ack(lane_ack),
    .lane_open(lane_open),
    .lane_deny(lane_deny),
    .busy(busy),
`ifdef TURNSTILE_PASS_COUNT_EN
    .pass_count(pass_count),
`endif
    .state_out(state_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_n++;
    if (act !== exp) begin
      errs_n++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) begin
      if (m[(model_ptr + i) % N]) return (model_ptr + i) % N;
    end
    return 0;
  endfunction

  function automatic bit code_valid(input logic [CW-1:0] c);
    return (int'(c) >= CMIN) && (int'(c) <= CMAX);
  endfunction

  function automatic logic [N*CW-1:0] all_codes(input logic [CW-1:0] c);
    logic [N*CW-1:0] v;
    for (int i = 0; i < N; i++) v[i*CW +: CW] = c;
    return v;
  endfunction

  // driver: predicts the batch, then drives requests and drops each on its ack
  task automatic run_batch(input logic [N-1:0] mask, input logic [N*CW-1:0] codes,
                           input int n_hold);
    logic [N-1:0] m;
    exp_t r;
    int   l;
    int   k;
    int   acks;
    bit   done;
    m = mask;
    k = 0;
    do begin
      l = model_pick(m);
      r = '0;
      r.lane      = 8'(l);
      r.grant     = code_valid(codes[l*CW +: CW]);
      r.first     = (k == 0);
      r.b2b       = (k != 0);
      r.apply_cyc = 32'(cyc);
      exp_q.push_back(r);
      if (r.grant) exp_grants++;
      model_ptr = (l + 1) % N;
      if (n_hold == 0) m[l] = 1'b0;
      k++;
    end while ((n_hold > 0) ? (k < n_hold) : (m != 0));

    lane_code = codes;
    lane_req  = mask;
    acks = 0;
    done = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(posedge clk); #1;
      if (lane_ack != 0) acks++;
      if (n_hold > 0) begin
        if (acks >= n_hold) lane_req = '0;
      end else begin
        lane_req = lane_req & ~lane_ack;
      end
      if (lane_req == 0 && !busy && exp_q.size() == 0) done = 1;
    end
    check("batch_complete", 32'(done), 32'd1);
    if (!done) begin
      exp_q.delete();
      lane_req = '0;
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!mon_en) begin
      phase = 0;
    end else begin
      check("one_hot_outputs", 32'($countones({lane_ack, lane_open, lane_deny}) <= 1), 32'd1);
      case (phase)
        0: begin
          check("idle_open", 32'(lane_open), 32'd0);
          check("idle_deny", 32'(lane_deny), 32'd0);
          if (lane_ack != 0) begin
            if (exp_q.size() == 0) begin
              check("unexpected_ack", 32'(lane_ack), 32'd0);
            end else begin
              cur = exp_q.pop_front();
              check("ack_lane", 32'(lane_ack), 32'(1) << cur.lane);
              check("ack_state", 32'(state_out), 32'd1);
              check("ack_busy", 32'(busy), 32'd1);
              if (cur.first) check("ack_latency", 32'(cyc), cur.apply_cyc + 32'd1);
              if (cur.b2b) check("back_to_back_gap", 32'(cyc - last_end), 32'd2);
              phase = 1;
            end
          end else begin
            check("idle_state", 32'(state_out), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
          end
        end
        1: begin
          check("post_ack_clear", 32'(lane_ack), 32'd0);
          check("outcome_busy", 32'(busy), 32'd1);
          if (cur.grant) begin
            check("grant_open", 32'(lane_open), 32'(1) << cur.lane);
            check("grant_deny", 32'(lane_deny), 32'd0);
            check("grant_state", 32'(state_out), 32'd2);
            open_cnt = 1;
            if (open_cnt == OPENC) begin
              last_end = cyc;
              phase = 0;
            end else begin
              phase = 2;
            end
          end else begin
            check("deny_lane", 32'(lane_deny), 32'(1) << cur.lane);
            check("deny_open", 32'(lane_open), 32'd0);
            check("deny_state", 32'(state_out), 32'd3);
            last_end = cyc;
            phase = 0;
          end
        end
        default: begin
          check("open_hold", 32'(lane_open), 32'(1) << cur.lane);
          check("open_no_ack", 32'(lane_ack | lane_deny), 32'd0);
          check("open_state", 32'(state_out), 32'd2);
          check("open_busy", 32'(busy), 32'd1);
          open_cnt++;
          if (open_cnt == OPENC) begin
            last_end = cyc;
            phase = 0;
          end
        end
      endcase
    end
  end

  // stimulus
  initial begin
    logic [N*CW-1:0] rc;
    logic [CW-1:0]   bnd[4];
    int              k0;
    bnd[0] = 4'd3; bnd[1] = 4'd4; bnd[2] = 4'd11; bnd[3] = 4'd12;
    rst_n = 1'b0;
    lane_req = '0;
    lane_code = '0;
    #1;
    check("reset_ack", 32'(lane_ack), 32'd0);
    check("reset_open", 32'(lane_open), 32'd0);
    check("reset_deny", 32'(lane_deny), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_state", 32'(state_out), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1;

    run_batch(4'b0001, all_codes(4'd5), 0);
    run_batch(4'b0010, all_codes(4'd3), 0);
    run_batch(4'b0100, all_codes(4'd4), 0);
    run_batch(4'b1000, all_codes(4'd11), 0);
    run_batch(4'b0001, all_codes(4'd12), 0);
    run_batch(4'b0010, all_codes(4'd15), 0);
    run_batch(4'b0001, all_codes(4'd0), 0);
    run_batch(4'b1111, all_codes(4'd7), 5);
    run_batch(4'b1111, {4'd12, 4'd4, 4'd3, 4'd11}, 0);

    // reset in the middle of a grant, at timer value 7
    k0 = cyc;
    run_reset_mid_grant(k0);
    run_batch(4'b1001, all_codes(4'd9), 0);
    run_batch(4'b1000, all_codes(4'd6), 0);

    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) rc[i*CW +: CW] = bnd[$urandom_range(0, 3)];
        else rc[i*CW +: CW] = CW'($urandom_range(0, 15));
      end
      run_batch(N'($urandom_range(1, 15)), rc, 0);
    end

`ifdef TURNSTILE_PASS_COUNT_EN
    check("pass_count", 32'(pass_count), 32'(exp_grants));
`endif
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", checks_n, errs_n);
    $finish;
  end

  task automatic run_reset_mid_grant(input int start_cyc);
    exp_t r;
    r = '0;
    r.lane      = 8'(model_pick(4'b0001));
    r.grant     = 1'b1;
    r.first     = 1'b1;
    r.apply_cyc = 32'(start_cyc);
    exp_q.push_back(r);
    model_ptr = 1;
    lane_code = all_codes(4'd5);
    lane_req  = 4'b0001;
    @(posedge clk); #1;
    lane_req = '0;
    repeat (8) @(posedge clk);
    #1;
    check("pre_reset_open", 32'(lane_open), 32'd1);
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    check("async_reset_open", 32'(lane_open), 32'd0);
    check("async_reset_state", 32'(state_out), 32'd0);
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_ack_deny", 32'(lane_ack | lane_deny), 32'd0);
    exp_q.delete();
    model_ptr = 0;
    exp_grants = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1;
  endtask

endmodule
